// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU-side byte write port and status of the UART transmitter.
//   WE/WD      : write strobe and byte (driven by the CPU side)
//   FULL/EMPTY : FIFO occupancy flags
//   COUNT      : bytes queued, excluding the one being shifted
//   BUSY       : transmitter is inside a frame
//   OVERRUN    : sticky flag, a write was dropped while FULL
//   uartTxPin  : serial line, idle high
interface uart_tx_fifo_if #(
  parameter int unsigned CNT_W = 5
);
  logic             WE;
  logic [7:0]       WD;
  logic             FULL;
  logic             EMPTY;
  logic [CNT_W-1:0] COUNT;
  logic             BUSY;
  logic             OVERRUN;
  logic             uartTxPin;

  modport master (
    output WE, WD,
    input  FULL, EMPTY, COUNT, BUSY, OVERRUN, uartTxPin
  );

  modport slave (
    input  WE, WD,
    output FULL, EMPTY, COUNT, BUSY, OVERRUN, uartTxPin
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8N1, LSB first.
//   CLK  : system clock, all state changes on the rising edge
//   RST  : synchronous active-high reset
//   bus  : uart_tx_fifo_if.slave (WE/WD in; FULL, EMPTY, COUNT, BUSY,
//          OVERRUN, uartTxPin out; all outputs registered)
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1, 11-bit frames).
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              pin_q, pin_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic              full_q, empty_q, busy_q, ovr_q;
  logic              push, pop, baud_last;
  logic [7:0]        mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // FULL is the pre-edge value, so a pop on the same edge never frees room
  assign push      = bus.WE && !full_q;
  assign baud_last = (baud_q == BAUD_LAST);

  // Next-state, line value and FIFO occupancy
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pin_d   = pin_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        pin_d  = 1'b1;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem[rptr_q];
`ifdef UART_TX_PARITY_EN
          par_d   = ^mem[rptr_q];
`endif
          state_d = S_START;
          pin_d   = 1'b0;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          pin_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            pin_d   = par_q;
`else
            state_d = S_STOP;
            pin_d   = 1'b1;
`endif
          end else begin
            // Next bit is shift_q[1]; the shift takes effect on this edge
            shift_d = shift_q >> 1;
            pin_d   = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_STOP;
          pin_d   = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
          pin_d   = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        pin_d   = 1'b1;
      end
    endcase
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // FIFO storage; contents need no reset since pointers are cleared
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wptr_q] <= bus.WD;
    end
  end

  // State, pointers and registered status
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      pin_q   <= 1'b1;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pin_q   <= pin_d;
      count_q <= count_d;
      wptr_q  <= wptr_q + PTR_W'(push);
      rptr_q  <= rptr_q + PTR_W'(pop);
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
      busy_q  <= (state_d != S_IDLE);
      ovr_q   <= ovr_q | (bus.WE & full_q);
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.FULL      = full_q;
  assign bus.EMPTY     = empty_q;
  assign bus.COUNT     = count_q;
  assign bus.BUSY      = busy_q;
  assign bus.OVERRUN   = ovr_q;
  assign bus.uartTxPin = pin_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4,
// FIFO_DEPTH=4). A time-based reference model predicts every output after
// every edge; a line decoder recovers transmitted bytes for order checks.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int D   = 4;
  localparam int CW  = $clog2(D) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int FB  = 11;
`else
  localparam int FB  = 10;
`endif
  localparam int FRAME_LEN = FB * CPB;

  logic CLK;
  logic RST;

  uart_tx_fifo_if #(.CNT_W(CW)) bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (D),
    .CNT_W       (CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of waiting bytes plus the start edge of the
  // frame on the line; the line value follows from elapsed time alone.
  int         cyc = 0;
  logic [7:0] mq[$];
  bit         m_fly;
  int         m_t0;
  logic [7:0] m_b;
  bit         m_ovr;

  // Line decoder state
  bit         rx_busy;
  int         rx_off;
  int         rx_start;
  logic [7:0] rx_sh;
  logic       rx_par;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_pq[$];

  typedef struct {
    bit         rst;
    bit         we;
    logic [7:0] wd;
    int         cnt;
    bit         full;
    bit         empty;
    bit         busy;
    bit         ovr;
    bit         pin;
  } vec_t;

  vec_t tbl[8];

  function automatic logic fbit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic void model_edge(bit rst_i, bit we_i, logic [7:0] wd_i);
    int pre;
    cyc++;
    if (rst_i) begin
      mq.delete();
      m_fly = 0;
      m_ovr = 0;
      return;
    end
    pre = mq.size();
    if (m_fly && (cyc - m_t0 == FRAME_LEN)) begin
      m_fly = 0;
    end else if (!m_fly && pre > 0) begin
      m_fly = 1;
      m_t0  = cyc;
      m_b   = mq.pop_front();
    end
    if (we_i) begin
      if (pre < D) mq.push_back(wd_i);
      else         m_ovr = 1;
    end
  endfunction

  function automatic void rx_step(logic pin, bit rst_i);
    int idx;
    if (rst_i) begin
      rx_busy = 0;
      return;
    end
    if (!rx_busy) begin
      if (pin == 1'b0) begin
        rx_busy  = 1;
        rx_off   = 0;
        rx_start = cyc;
      end
    end else begin
      rx_off++;
      if (rx_off % CPB == CPB / 2) begin
        idx = rx_off / CPB;
        if (idx >= 1 && idx <= 8) begin
          rx_sh[idx-1] = pin;
        end else if (idx == FB - 1) begin
          rx_busy = 0;
          rx_q.push_back(rx_sh);
          rx_t.push_back(rx_start);
          rx_pq.push_back(rx_par);
        end else if (idx == 9) begin
          rx_par = pin;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_model();
    logic e_pin;
    int   sz;
    sz    = mq.size();
    e_pin = m_fly ? fbit(m_b, (cyc - m_t0) / CPB) : 1'b1;
    n_vec++;
    if (int'(bus.COUNT) != sz || bus.FULL !== logic'(sz == D) ||
        bus.EMPTY !== logic'(sz == 0) || bus.BUSY !== logic'(m_fly) ||
        bus.OVERRUN !== logic'(m_ovr) || bus.uartTxPin !== e_pin) begin
      n_err++;
      $display("FAIL model cyc=%0d got cnt=%0d full=%b empty=%b busy=%b ovr=%b tx=%b want cnt=%0d full=%b empty=%b busy=%b ovr=%b tx=%b",
               cyc, bus.COUNT, bus.FULL, bus.EMPTY, bus.BUSY, bus.OVERRUN, bus.uartTxPin,
               sz, sz == D, sz == 0, m_fly, m_ovr, e_pin);
    end
  endtask

  // One clock edge: drive inputs, advance model and decoder, optionally check
  task automatic tick(input bit rst_i, input bit we_i, input logic [7:0] wd_i, input bit do_chk);
    RST    = rst_i;
    bus.WE = we_i;
    bus.WD = wd_i;
    @(posedge CLK);
    model_edge(rst_i, we_i, wd_i);
    #1;
    rx_step(bus.uartTxPin, rst_i);
    if (do_chk) check_model();
  endtask

  task automatic do_reset();
    tick(1, 0, 8'h00, 1);
    rx_q.delete();
    rx_t.delete();
    rx_pq.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((m_fly || mq.size() != 0) && n < 3000) begin
      tick(0, 0, 8'h00, 1);
      n++;
    end
    repeat (3) tick(0, 0, 8'h00, 1);
    chk("drain_bound", int'(n < 3000), 1);
  endtask

  // Write one byte into an idle, empty FIFO and time the frame via BUSY
  task automatic frame_test(input string nm, input logic [7:0] b);
    int k;
    do_reset();
    tick(0, 1, b, 1);
    for (k = 1; k < 200; k++) begin
      tick(0, 0, 8'h00, 1);
      if (k > 1 && bus.BUSY === 1'b0) break;
    end
    chk({nm, "_busy_drop"}, k, FRAME_LEN + 1);
    chk({nm, "_rx_n"}, rx_q.size(), 1);
    if (rx_q.size() > 0) chk({nm, "_rx_byte"}, int'(rx_q[0]), int'(b));
  endtask

  initial begin
    int         trans;
    logic       prev;
    int         nxt;
    int         guard;
    int         pw;
    logic [7:0] exp_fill[5];
    logic [7:0] xs[3];

    RST    = 1'b1;
    bus.WE = 1'b0;
    bus.WD = 8'h00;

    // Reset, then 6 back-to-back writes into a depth-4 FIFO
    tbl[0] = '{1, 0, 8'h00, 0, 0, 1, 0, 0, 1};
    tbl[1] = '{0, 1, 8'h11, 1, 0, 0, 0, 0, 1};
    tbl[2] = '{0, 1, 8'h21, 1, 0, 0, 1, 0, 0};
    tbl[3] = '{0, 1, 8'h32, 2, 0, 0, 1, 0, 0};
    tbl[4] = '{0, 1, 8'h43, 3, 0, 0, 1, 0, 0};
    tbl[5] = '{0, 1, 8'h54, 4, 1, 0, 1, 0, 0};
    tbl[6] = '{0, 1, 8'h65, 4, 1, 0, 1, 1, 1};
    tbl[7] = '{0, 0, 8'h00, 4, 1, 0, 1, 1, 1};
    exp_fill = '{8'h11, 8'h21, 8'h32, 8'h43, 8'h54};

    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].rst, tbl[i].we, tbl[i].wd, 0);
      n_vec++;
      if (int'(bus.COUNT) != tbl[i].cnt || bus.FULL !== tbl[i].full ||
          bus.EMPTY !== tbl[i].empty || bus.BUSY !== tbl[i].busy ||
          bus.OVERRUN !== tbl[i].ovr || bus.uartTxPin !== tbl[i].pin) begin
        n_err++;
        $display("FAIL vec%0d got cnt=%0d full=%b empty=%b busy=%b ovr=%b tx=%b want cnt=%0d full=%b empty=%b busy=%b ovr=%b tx=%b",
                 i, bus.COUNT, bus.FULL, bus.EMPTY, bus.BUSY, bus.OVERRUN, bus.uartTxPin,
                 tbl[i].cnt, tbl[i].full, tbl[i].empty, tbl[i].busy, tbl[i].ovr, tbl[i].pin);
      end
      if (i == 0) begin
        rx_q.delete();
        rx_t.delete();
        rx_pq.delete();
      end
    end
    drain();
    chk("fill_rx_n", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < rx_q.size()) chk($sformatf("fill_rx%0d", i), int'(rx_q[i]), int'(exp_fill[i]));
    end
    chk("fill_ovr_sticky", int'(bus.OVERRUN), 1);

    // Single frame timing
    frame_test("a5", 8'hA5);

    // Reset in the middle of the data bits
    do_reset();
    tick(0, 1, 8'h55, 1);
    repeat (10) tick(0, 0, 8'h00, 1);
    tick(1, 0, 8'h00, 1);
    chk("rst_mid_tx", int'(bus.uartTxPin), 1);
    chk("rst_mid_busy", int'(bus.BUSY), 0);
    chk("rst_mid_count", int'(bus.COUNT), 0);
    trans = 0;
    prev  = bus.uartTxPin;
    repeat (60) begin
      tick(0, 0, 8'h00, 1);
      if (bus.uartTxPin !== prev) trans++;
      prev = bus.uartTxPin;
    end
    chk("rst_quiet_edges", trans, 0);
    chk("rst_quiet_rx", rx_q.size(), 0);

    // Push and pop on the same edge with one byte waiting in IDLE
    xs = '{8'h3C, 8'hC3, 8'h9E};
    do_reset();
    tick(0, 1, xs[0], 1);
    tick(0, 0, 8'h00, 1);
    tick(0, 1, xs[1], 1);
    guard = 0;
    while (m_fly && guard < 200) begin
      tick(0, 0, 8'h00, 1);
      guard++;
    end
    chk("sim_reach_idle", int'(bus.BUSY), 0);
    chk("sim_pre_count", int'(bus.COUNT), 1);
    tick(0, 1, xs[2], 1);
    chk("sim_count", int'(bus.COUNT), 1);
    drain();
    chk("sim_rx_n", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rx_q.size()) chk($sformatf("sim_rx%0d", i), int'(rx_q[i]), int'(xs[i]));
    end
    if (rx_t.size() == 3) begin
      chk("sim_gap01", rx_t[1] - rx_t[0], FRAME_LEN + 1);
      chk("sim_gap12", rx_t[2] - rx_t[1], FRAME_LEN + 1);
    end

    // Pointer wrap: 10 bytes, writing only when room is predicted
    do_reset();
    nxt   = 0;
    guard = 0;
    while (nxt < 10 && guard < 2000) begin
      if (mq.size() < D) begin
        tick(0, 1, 8'(nxt), 1);
        nxt++;
      end else begin
        tick(0, 0, 8'h00, 1);
      end
      guard++;
    end
    drain();
    chk("wrap_rx_n", rx_q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < rx_q.size()) chk($sformatf("wrap_rx%0d", i), int'(rx_q[i]), i);
    end
    chk("wrap_ovr", int'(bus.OVERRUN), 0);

`ifdef UART_TX_PARITY_EN
    frame_test("par07", 8'h07);
    if (rx_pq.size() > 0) chk("par07_bit", int'(rx_pq[0]), 1);
`endif

    // Randomised traffic with varying write density and rare resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      case ((i / 500) % 3)
        0:       pw = 85;
        1:       pw = 25;
        default: pw = 5;
      endcase
      tick(bit'($urandom_range(0, 599) == 0), bit'($urandom_range(0, 99) < pw),
           8'($urandom_range(0, 255)), 1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
